// File: rtl/motor_pkg.sv
// Shared types and coil patterns for the stepper sequencer.
// HALF_STEP_EN selects the 8-phase half-step sequence.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JOG  = 2'd2
  } state_t;

  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_STOP  = 2'b00;

  localparam logic [3:0] COILS_OFF = 4'b0000;

  // Phase p occupies bits [4p+3:4p].
  localparam logic [15:0] FULL_PAT = {
    4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  localparam logic [31:0] HALF_PAT = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

`ifdef HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  function automatic logic [3:0] coil_pat(
    input logic [PH_W-1:0] p
  );
`ifdef HALF_STEP_EN
    return HALF_PAT[{p, 2'b00} +: 4];
`else
    return FULL_PAT[{p, 2'b00} +: 4];
`endif
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: 1-cycle tick every (BASE_DIV >> motorSpeed)
// clocks; the period is resampled on every tick and on clear.
module step_prescaler #(
  parameter int BASE_DIV = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] motorSpeed,
  output logic       tick
);

  localparam int CW = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;

  localparam logic [CW-1:0] L0 = CW'(BASE_DIV - 1);
  localparam logic [CW-1:0] L1 = CW'((BASE_DIV >> 1) - 1);
  localparam logic [CW-1:0] L2 = CW'((BASE_DIV >> 2) - 1);
  localparam logic [CW-1:0] L3 = CW'((BASE_DIV >> 3) - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_last;
  logic [CW-1:0] w_last;

  always_comb begin
    w_last = L0;
    unique case (motorSpeed)
      2'd0: w_last = L0;
      2'd1: w_last = L1;
      2'd2: w_last = L2;
      2'd3: w_last = L3;
    endcase
  end

  assign tick = (r_cnt == r_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_last <= L0;
    end else if (clear || tick) begin
      r_cnt  <= '0;
      r_last <= w_last;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Stepper motor sequencer: continuous run plus debounced-edge jog.
// Define HALF_STEP_EN for the 8-phase half-step drive.
module step_sequencer
  import motor_pkg::*;
#(
  parameter int BASE_DIV  = 25_000_000,
  parameter int JOG_STEPS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       direction,
  input  logic       buttonRight,
  input  logic       buttonLeft,
  input  logic [1:0] motorSpeed,
  output logic [3:0] lights,
  output logic [1:0] rightLeft,
  output logic       busy
);

  state_t          r_state;
  logic [PH_W-1:0] r_phase;
  logic [7:0]      r_jcnt;
  logic            r_jdir;
  logic [1:0]      r_sync_r;
  logic [1:0]      r_sync_l;
  logic            r_prev_r;
  logic            r_prev_l;
  logic [3:0]      r_lights;
  logic [1:0]      r_rl;
  logic            r_busy;

  logic            w_tick;
  logic            w_clear;
  logic            w_edge_r;
  logic            w_edge_l;
  logic            w_jog_go;
  logic            w_dir;
  logic            w_last;
  logic [PH_W-1:0] w_ph_nx;

  assign w_edge_r = r_sync_r[1] & ~r_prev_r;
  assign w_edge_l = r_sync_l[1] & ~r_prev_l;
  assign w_jog_go = (w_edge_r ^ w_edge_l) & ~enable;

  assign w_dir   = (r_state == RUN) ? direction : r_jdir;
  assign w_ph_nx = w_dir ? r_phase + PH_W'(1)
                         : r_phase - PH_W'(1);
  assign w_last  = (r_jcnt == 8'd1);

  // Prescaler restarts on every entry into RUN or JOG.
  assign w_clear =
    ((r_state == IDLE) && (enable || w_jog_go)) ||
    ((r_state == JOG) && w_tick && w_last && enable);

  step_prescaler #(
    .BASE_DIV (BASE_DIV)
  ) u_presc (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_clear),
    .motorSpeed (motorSpeed),
    .tick       (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_jcnt   <= '0;
      r_jdir   <= 1'b0;
      r_sync_r <= '0;
      r_sync_l <= '0;
      r_prev_r <= 1'b0;
      r_prev_l <= 1'b0;
      r_lights <= COILS_OFF;
      r_rl     <= DIR_STOP;
      r_busy   <= 1'b0;
    end else begin
      r_sync_r <= {r_sync_r[0], buttonRight};
      r_sync_l <= {r_sync_l[0], buttonLeft};
      r_prev_r <= r_sync_r[1];
      r_prev_l <= r_sync_l[1];
      unique case (r_state)
        IDLE: begin
          if (enable) begin
            r_state  <= RUN;
            r_lights <= coil_pat(r_phase);
            r_rl     <= direction ? DIR_RIGHT : DIR_LEFT;
            r_busy   <= 1'b1;
          end else if (w_jog_go) begin
            r_state  <= JOG;
            r_jcnt   <= 8'(JOG_STEPS);
            r_jdir   <= w_edge_r;
            r_lights <= coil_pat(r_phase);
            r_rl     <= w_edge_r ? DIR_RIGHT : DIR_LEFT;
            r_busy   <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            r_state  <= IDLE;
            r_lights <= COILS_OFF;
            r_rl     <= DIR_STOP;
            r_busy   <= 1'b0;
          end else begin
            r_rl <= direction ? DIR_RIGHT : DIR_LEFT;
            if (w_tick) begin
              r_phase  <= w_ph_nx;
              r_lights <= coil_pat(w_ph_nx);
            end
          end
        end
        JOG: begin
          if (w_tick) begin
            r_phase <= w_ph_nx;
            r_jcnt  <= r_jcnt - 8'd1;
            if (!w_last) begin
              r_lights <= coil_pat(w_ph_nx);
            end else if (enable) begin
              r_state  <= RUN;
              r_lights <= coil_pat(w_ph_nx);
              r_rl     <= direction ? DIR_RIGHT : DIR_LEFT;
            end else begin
              r_state  <= IDLE;
              r_lights <= COILS_OFF;
              r_rl     <= DIR_STOP;
              r_busy   <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lights    = r_lights;
  assign rightLeft = r_rl;
  assign busy      = r_busy;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with BASE_DIV=8, JOG_STEPS=4.
// Define HALF_STEP_EN to check the half-step sequence.
module tb_step_sequencer;

  localparam int BASE = 8;
  localparam int JS   = 4;

`ifdef HALF_STEP_EN
  localparam int NPH = 8;
  localparam logic [3:0] SEQ [8] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0100, 4'b1100, 4'b1000, 4'b1001
  };
`else
  localparam int NPH = 4;
  localparam logic [3:0] SEQ [4] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000
  };
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       direction = 1'b0;
  logic       buttonRight = 1'b0;
  logic       buttonLeft = 1'b0;
  logic [1:0] motorSpeed = 2'b00;
  logic [3:0] lights;
  logic [1:0] rightLeft;
  logic       busy;

  int checks = 0;
  int errors = 0;

  step_sequencer #(
    .BASE_DIV  (BASE),
    .JOG_STEPS (JS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .direction   (direction),
    .buttonRight (buttonRight),
    .buttonLeft  (buttonLeft),
    .motorSpeed  (motorSpeed),
    .lights      (lights),
    .rightLeft   (rightLeft),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] seq_r(input int k);
    return SEQ[k % NPH];
  endfunction

  function automatic logic [3:0] seq_l(input int k);
    return SEQ[(NPH - (k % NPH)) % NPH];
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    enable = 1'b0;
    direction = 1'b0;
    buttonRight = 1'b0;
    buttonLeft = 1'b0;
    motorSpeed = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if (lights !== 4'b0000) begin
      errors++;
      $display("FAIL reset_lights got %b want 0000", lights);
    end
    checks++;
    if (rightLeft !== 2'b00) begin
      errors++;
      $display("FAIL reset_rl got %b want 00", rightLeft);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || lights !== 4'b0000) begin
      errors++;
      $display("FAIL idle_hold got busy=%b lights=%b want 0/0000",
               busy, lights);
    end
  endtask

  task automatic test_run_right();
    apply_reset();
    enable = 1'b1;
    direction = 1'b1;
    motorSpeed = 2'b00;
    @(negedge clock);
    checks++;
    if (lights !== seq_r(0) || busy !== 1'b1 || rightLeft !== 2'b10) begin
      errors++;
      $display("FAIL run_entry got l=%b b=%b rl=%b want %b/1/10",
               lights, busy, rightLeft, seq_r(0));
    end
    for (int k = 1; k <= NPH; k++) begin
      repeat (7) @(negedge clock);
      checks++;
      if (lights !== seq_r(k - 1)) begin
        errors++;
        $display("FAIL run_right_hold%0d got %b want %b",
                 k, lights, seq_r(k - 1));
      end
      @(negedge clock);
      checks++;
      if (lights !== seq_r(k)) begin
        errors++;
        $display("FAIL run_right_step%0d got %b want %b",
                 k, lights, seq_r(k));
      end
    end
    checks++;
    if (rightLeft !== 2'b10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_right_flags got rl=%b b=%b want 10/1",
               rightLeft, busy);
    end
  endtask

  task automatic test_run_left();
    apply_reset();
    enable = 1'b1;
    direction = 1'b0;
    motorSpeed = 2'b10;
    @(negedge clock);
    checks++;
    if (lights !== seq_r(0) || rightLeft !== 2'b01) begin
      errors++;
      $display("FAIL left_entry got l=%b rl=%b want %b/01",
               lights, rightLeft, seq_r(0));
    end
    for (int k = 1; k <= 4; k++) begin
      repeat (2) @(negedge clock);
      checks++;
      if (lights !== seq_l(k)) begin
        errors++;
        $display("FAIL run_left_step%0d got %b want %b",
                 k, lights, seq_l(k));
      end
    end
    motorSpeed = 2'b00;
    repeat (2) @(negedge clock);
    checks++;
    if (lights !== seq_l(5)) begin
      errors++;
      $display("FAIL speed_latch got %b want %b", lights, seq_l(5));
    end
    repeat (7) @(negedge clock);
    checks++;
    if (lights !== seq_l(5)) begin
      errors++;
      $display("FAIL speed_slow_hold got %b want %b", lights, seq_l(5));
    end
    @(negedge clock);
    checks++;
    if (lights !== seq_l(6) || rightLeft !== 2'b01) begin
      errors++;
      $display("FAIL speed_slow_step got l=%b rl=%b want %b/01",
               lights, rightLeft, seq_l(6));
    end
    enable = 1'b0;
    @(negedge clock);
    checks++;
    if (lights !== 4'b0000 || busy !== 1'b0 || rightLeft !== 2'b00) begin
      errors++;
      $display("FAIL run_stop got l=%b b=%b rl=%b want 0000/0/00",
               lights, busy, rightLeft);
    end
  endtask

  task automatic test_jog_left();
    apply_reset();
    buttonLeft = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL jog_sync_delay got busy=%b want 0", busy);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || rightLeft !== 2'b01 || lights !== seq_r(0)) begin
      errors++;
      $display("FAIL jog_entry got b=%b rl=%b l=%b want 1/01/%b",
               busy, rightLeft, lights, seq_r(0));
    end
    buttonLeft = 1'b0;
    for (int k = 1; k < JS; k++) begin
      repeat (8) @(negedge clock);
      checks++;
      if (lights !== seq_l(k)) begin
        errors++;
        $display("FAIL jog_left_step%0d got %b want %b",
                 k, lights, seq_l(k));
      end
    end
    repeat (8) @(negedge clock);
    checks++;
    if (lights !== 4'b0000 || busy !== 1'b0 || rightLeft !== 2'b00) begin
      errors++;
      $display("FAIL jog_done got l=%b b=%b rl=%b want 0000/0/00",
               lights, busy, rightLeft);
    end
  endtask

  task automatic test_jog_both();
    repeat (2) @(negedge clock);
    buttonLeft = 1'b1;
    buttonRight = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || lights !== 4'b0000) begin
      errors++;
      $display("FAIL jog_both got b=%b l=%b want 0/0000", busy, lights);
    end
    buttonLeft = 1'b0;
    buttonRight = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_jog_to_run();
    apply_reset();
    buttonRight = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || rightLeft !== 2'b10 || lights !== seq_r(0)) begin
      errors++;
      $display("FAIL jogr_entry got b=%b rl=%b l=%b want 1/10/%b",
               busy, rightLeft, lights, seq_r(0));
    end
    buttonRight = 1'b0;
    repeat (8) @(negedge clock);
    checks++;
    if (lights !== seq_r(1)) begin
      errors++;
      $display("FAIL jogr_step1 got %b want %b", lights, seq_r(1));
    end
    repeat (8) @(negedge clock);
    checks++;
    if (lights !== seq_r(2)) begin
      errors++;
      $display("FAIL jogr_step2 got %b want %b", lights, seq_r(2));
    end
    enable = 1'b1;
    direction = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (lights !== seq_r(3) || busy !== 1'b1) begin
      errors++;
      $display("FAIL jogr_step3 got l=%b b=%b want %b/1",
               lights, busy, seq_r(3));
    end
    repeat (8) @(negedge clock);
    checks++;
    if (lights !== seq_r(4) || busy !== 1'b1 || rightLeft !== 2'b10) begin
      errors++;
      $display("FAIL jogr_to_run got l=%b b=%b rl=%b want %b/1/10",
               lights, busy, rightLeft, seq_r(4));
    end
    repeat (7) @(negedge clock);
    checks++;
    if (lights !== seq_r(4)) begin
      errors++;
      $display("FAIL run_after_jog_hold got %b want %b",
               lights, seq_r(4));
    end
    @(negedge clock);
    checks++;
    if (lights !== seq_r(5)) begin
      errors++;
      $display("FAIL run_after_jog got %b want %b", lights, seq_r(5));
    end
  endtask

  task automatic test_reset_mid_run();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (lights !== 4'b0000 || rightLeft !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got l=%b rl=%b b=%b want 0000/00/0",
               lights, rightLeft, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b1;
    direction = 1'b1;
    motorSpeed = 2'b00;
    @(negedge clock);
    checks++;
    if (lights !== seq_r(0) || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_phase0 got l=%b b=%b want %b/1",
               lights, busy, seq_r(0));
    end
    repeat (8) @(negedge clock);
    checks++;
    if (lights !== seq_r(1)) begin
      errors++;
      $display("FAIL restart_step1 got %b want %b", lights, seq_r(1));
    end
  endtask

  initial begin
    test_reset();
    test_run_right();
    test_run_left();
    test_jog_left();
    test_jog_both();
    test_jog_to_run();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
